// File: rtl/intra4x4_mode_decision_pkg.sv
// intra4x4_mode_decision_pkg: shared widths, H.264 4x4 intra mode encodings and FSM states
package intra4x4_mode_decision_pkg;
  localparam int PIX_W_D = 8;
  localparam int SAD_W_D = 12;
  localparam int MODE_W_D = 4;
  typedef enum logic [3:0] {VERT, HORZ, DC, DDL, DDR, VR, HD, VL, HU} mode_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCUM, S_CMP, S_DONE} state_t;
endpackage

// File: rtl/intra4x4_mode_decision_sad_row4.sv
// sad_row4: combinational sum of absolute differences over one 4-pixel row
module sad_row4 #(
  parameter int PIX_W = 8
) (
  input  logic [4*PIX_W-1:0] a,
  input  logic [4*PIX_W-1:0] b,
  output logic [PIX_W+1:0]   sum
);
  logic [PIX_W-1:0] d [4];
  for (genvar i = 0; i < 4; i++) begin : g_d
    assign d[i] = a[i*PIX_W +: PIX_W] > b[i*PIX_W +: PIX_W] ?
                  a[i*PIX_W +: PIX_W] - b[i*PIX_W +: PIX_W] :
                  b[i*PIX_W +: PIX_W] - a[i*PIX_W +: PIX_W];
  end
  assign sum = (PIX_W+2)'(d[0]) + (PIX_W+2)'(d[1]) + (PIX_W+2)'(d[2]) + (PIX_W+2)'(d[3]);
endmodule

// File: rtl/intra4x4_mode_decision.sv
// intra4x4_mode_decision: SAD-scores 4x4 intra candidates row by row and keeps the best mode
module intra4x4_mode_decision
  import intra4x4_mode_decision_pkg::*;
#(
  parameter int PIX_W = PIX_W_D,
  parameter int SAD_W = SAD_W_D,
  parameter int MODE_W = MODE_W_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                block_start,
  input  logic [16*PIX_W-1:0] orig_blk,
  input  logic                pred_valid,
  output logic                pred_ready,
  input  logic [MODE_W-1:0]   pred_mode,
  input  logic                pred_last,
  input  logic [16*PIX_W-1:0] pred_blk,
  output logic                done,
  output logic [MODE_W-1:0]   best_mode,
  output logic [SAD_W-1:0]    best_sad,
  output logic [16*PIX_W-1:0] best_blk
);
  state_t state, state_nx;
  logic [16*PIX_W-1:0] orig, pred;
  logic [MODE_W-1:0] mode;
  logic last;
  logic [SAD_W-1:0] acc;
  logic [1:0] row;
  logic [PIX_W+1:0] row_sad;
  logic transfer;

  sad_row4 #(.PIX_W(PIX_W)) u_sad (
    .a  (orig[int'(row)*4*PIX_W +: 4*PIX_W]),
    .b  (pred[int'(row)*4*PIX_W +: 4*PIX_W]),
    .sum(row_sad)
  );

  // block_start outranks a pending candidate so a new block never inherits a stale transfer
  assign pred_ready = state == S_WAIT && !block_start;
  assign transfer = pred_valid && pred_ready;
  assign done = state == S_DONE;

  always_comb begin
    state_nx = block_start ? S_WAIT :
               state == S_WAIT ? (pred_valid ? S_ACCUM : S_WAIT) :
               state == S_ACCUM ? (row == 2'd3 ? S_CMP : S_ACCUM) :
               state == S_CMP ? (last ? S_DONE : S_WAIT) : S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      orig <= '0;
      pred <= '0;
      mode <= '0;
      last <= 1'b0;
      acc <= '0;
      row <= '0;
      best_mode <= '0;
      best_sad <= '1;
      best_blk <= '0;
    end else begin
      state <= state_nx;
      if (block_start) begin
        orig <= orig_blk;
        acc <= '0;
        row <= '0;
        best_mode <= '0;
        best_sad <= '1;
        best_blk <= '0;
      end else if (transfer) begin
        pred <= pred_blk;
        mode <= pred_mode;
        last <= pred_last;
        acc <= '0;
        row <= '0;
      end else if (state == S_ACCUM) begin
        acc <= acc + SAD_W'(row_sad);
        row <= row + 2'd1;
      end else if (state == S_CMP && acc < best_sad) begin
        best_sad <= acc;
        best_mode <= mode;
        best_blk <= pred;
      end
    end
  end
endmodule

// File: tb/tb_intra4x4_mode_decision.sv
// tb_intra4x4_mode_decision: randomized scenarios checked against a plain-arithmetic SAD/min model
module tb_intra4x4_mode_decision;
  logic clk = 1'b0;
  logic reset, block_start, pred_valid, pred_last, pred_ready, done;
  logic [127:0] orig_blk, pred_blk, best_blk;
  logic [3:0] pred_mode, best_mode;
  logic [11:0] best_sad;
  int checks = 0, failures = 0, cyc = 0;
  logic [127:0] c_pred[$];
  logic [3:0] c_mode[$];
  int r_xfers, r_ready_bad, r_gap_min, r_done_cyc, r_last_xfer;
  bit r_done;
  logic [3:0] cap_mode;
  logic [11:0] cap_sad;
  logic [127:0] cap_blk;

  intra4x4_mode_decision dut (
    .clk(clk), .reset(reset), .block_start(block_start), .orig_blk(orig_blk),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_mode(pred_mode),
    .pred_last(pred_last), .pred_blk(pred_blk), .done(done), .best_mode(best_mode),
    .best_sad(best_sad), .best_blk(best_blk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sad_of(input logic [127:0] o, input logic [127:0] p);
    int s = 0;
    for (int k = 0; k < 16; k++) begin
      int a = int'(o[k*8 +: 8]);
      int b = int'(p[k*8 +: 8]);
      s += a > b ? a - b : b - a;
    end
    return s;
  endfunction

  function automatic logic [127:0] bump(input logic [127:0] o, input int n, input int d, input bit up);
    logic [127:0] r;
    r = o;
    for (int k = 0; k < n; k++) begin
      int v = int'(o[k*8 +: 8]);
      if (up) v = (v + d <= 255) ? v + d : v - d;
      else v = (v - d >= 0) ? v - d : v + d;
      r[k*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic ref_best(input logic [127:0] o, output logic [3:0] m, output logic [11:0] s, output logic [127:0] b);
    int best = 4095;
    m = '0; b = '0;
    foreach (c_pred[i]) begin
      int sd = sad_of(o, c_pred[i]);
      if (sd < best) begin best = sd; m = c_mode[i]; b = c_pred[i]; end
    end
    s = 12'(best);
  endtask

  task automatic start_block(input logic [127:0] o);
    block_start = 1'b1;
    orig_blk = o;
    @(negedge clk);
    block_start = 1'b0;
  endtask

  // Presents the queued candidates; abort_at>0 returns that many cycles after the final transfer
  task automatic play(input bit mark_last, input int stall_max, input int abort_at);
    int idx = 0, prev = -1, n = c_pred.size();
    int stall = $urandom_range(stall_max, 0);
    r_xfers = 0; r_ready_bad = 0; r_gap_min = 1000; r_done = 0; r_done_cyc = -1;
    for (int t = 0; t < 3000; t++) begin
      if (r_done) break;
      if (abort_at > 0 && idx == n && prev >= 0 && cyc - prev == abort_at) break;
      if (idx < n) begin
        pred_blk = c_pred[idx]; pred_mode = c_mode[idx];
        pred_last = mark_last && idx == n - 1; pred_valid = stall == 0;
      end else pred_valid = 1'b0;
      #1;
      if (prev >= 0 && cyc - prev >= 1 && cyc - prev <= 5 && pred_ready) r_ready_bad++;
      if (done) begin r_done = 1; r_done_cyc = cyc; cap_mode = best_mode; cap_sad = best_sad; cap_blk = best_blk; end
      if (pred_valid && pred_ready) begin
        if (prev >= 0 && cyc - prev < r_gap_min) r_gap_min = cyc - prev;
        prev = cyc; r_xfers++; idx++; stall = $urandom_range(stall_max, 0);
      end else if (stall > 0) stall--;
      @(negedge clk);
    end
    pred_valid = 1'b0;
    r_last_xfer = prev;
  endtask

  task automatic count_done(input int n, output int extra);
    extra = 0;
    for (int i = 0; i < n; i++) begin #1; if (done) extra++; @(negedge clk); end
  endtask

  task automatic test_reset();
    reset = 1'b0; pred_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks += 5;
    if (pred_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", pred_ready); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (best_mode !== 4'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", best_mode); end
    if (best_sad !== 12'hfff) begin failures++; $display("FAIL reset_sad got=%0h exp=fff", best_sad); end
    if (best_blk !== 128'd0) begin failures++; $display("FAIL reset_blk got=%0h exp=0", best_blk); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (pred_ready !== 1'b0) begin failures++; $display("FAIL idle_ready cyc%0d got=%b exp=0", i, pred_ready); end
      @(negedge clk);
    end
    pred_valid = 1'b0;
  endtask

  task automatic test_best_match();
    logic [127:0] o = {16{8'h80}};
    int extra;
    c_pred.delete(); c_mode.delete();
    for (int m = 0; m < 9; m++) begin c_mode.push_back(4'(m)); c_pred.push_back(m == 5 ? o : bump(o, 16, 1, 1)); end
    start_block(o);
    play(1, 0, 0);
    count_done(3, extra);
    checks += 7;
    if (!r_done) begin failures++; $display("FAIL match_done got=0 exp=1"); end
    if (cap_mode !== 4'd5) begin failures++; $display("FAIL match_mode got=%0d exp=5", cap_mode); end
    if (cap_sad !== 12'd0) begin failures++; $display("FAIL match_sad got=%0d exp=0", cap_sad); end
    if (cap_blk !== o) begin failures++; $display("FAIL match_blk got=%0h exp=%0h", cap_blk, o); end
    if (r_xfers != 9) begin failures++; $display("FAIL match_xfers got=%0d exp=9", r_xfers); end
    if (r_gap_min != 6) begin failures++; $display("FAIL match_gap got=%0d exp=6", r_gap_min); end
    if (extra != 0) begin failures++; $display("FAIL match_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_max_sad();
    c_pred.delete(); c_mode.delete();
    c_pred.push_back({16{8'hff}}); c_mode.push_back(4'd2);
    start_block(128'd0);
    play(1, 0, 0);
    checks += 4;
    if (!r_done) begin failures++; $display("FAIL max_done got=0 exp=1"); end
    if (cap_sad !== 12'hff0) begin failures++; $display("FAIL max_sad got=%0h exp=ff0", cap_sad); end
    if (cap_mode !== 4'd2) begin failures++; $display("FAIL max_mode got=%0d exp=2", cap_mode); end
    if (r_done_cyc - r_last_xfer != 6) begin failures++; $display("FAIL max_latency got=%0d exp=6", r_done_cyc - r_last_xfer); end
  endtask

  task automatic test_tie();
    logic [127:0] o = {$urandom, $urandom, $urandom, $urandom};
    c_pred.delete(); c_mode.delete();
    c_pred.push_back(bump(o, 16, 1, 1)); c_mode.push_back(4'd1);
    c_pred.push_back(bump(o, 16, 1, 0)); c_mode.push_back(4'd3);
    start_block(o);
    play(1, 0, 0);
    checks += 3;
    if (cap_mode !== 4'd1) begin failures++; $display("FAIL tie_mode got=%0d exp=1", cap_mode); end
    if (cap_sad !== 12'd16) begin failures++; $display("FAIL tie_sad got=%0d exp=16", cap_sad); end
    if (cap_blk !== c_pred[0]) begin failures++; $display("FAIL tie_blk got=%0h exp=%0h", cap_blk, c_pred[0]); end
  endtask

  task automatic test_stalls();
    logic [3:0] em; logic [11:0] es; logic [127:0] eb;
    for (int blk = 0; blk < 4; blk++) begin
      logic [127:0] o = {$urandom, $urandom, $urandom, $urandom};
      c_pred.delete(); c_mode.delete();
      for (int m = 0; m < 9; m++) begin
        c_mode.push_back(4'($urandom_range(15, 0)));
        c_pred.push_back(blk == 3 ? {$urandom, $urandom, $urandom, $urandom} :
                         bump(o, $urandom_range(16, 0), $urandom_range(5, 0), 1'($urandom)));
      end
      ref_best(o, em, es, eb);
      start_block(o);
      play(1, 3, 0);
      checks += 7;
      if (!r_done) begin failures++; $display("FAIL stall%0d_done got=0 exp=1", blk); end
      if (cap_mode !== em) begin failures++; $display("FAIL stall%0d_mode got=%0d exp=%0d", blk, cap_mode, em); end
      if (cap_sad !== es) begin failures++; $display("FAIL stall%0d_sad got=%0d exp=%0d", blk, cap_sad, es); end
      if (cap_blk !== eb) begin failures++; $display("FAIL stall%0d_blk got=%0h exp=%0h", blk, cap_blk, eb); end
      if (r_xfers != 9) begin failures++; $display("FAIL stall%0d_xfers got=%0d exp=9", blk, r_xfers); end
      if (r_ready_bad != 0) begin failures++; $display("FAIL stall%0d_ready_busy got=%0d exp=0", blk, r_ready_bad); end
      if (r_gap_min < 6) begin failures++; $display("FAIL stall%0d_gap got=%0d exp>=6", blk, r_gap_min); end
    end
  endtask

  task automatic test_abort();
    logic [127:0] o = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] o2 = {$urandom, $urandom, $urandom, $urandom};
    int extra;
    c_pred.delete(); c_mode.delete();
    for (int m = 0; m < 4; m++) begin c_mode.push_back(4'(m)); c_pred.push_back(bump(o, 4, 1, 1)); end
    start_block(o);
    play(0, 0, 2);
    block_start = 1'b1; orig_blk = o2;
    #1; checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    if (pred_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", pred_ready); end
    @(negedge clk);
    block_start = 1'b0;
    c_pred.delete(); c_mode.delete();
    c_pred.push_back(bump(o2, 1, 7, 1)); c_mode.push_back(4'd6);
    c_pred.push_back(bump(o2, 1, 3, 1)); c_mode.push_back(4'd8);
    play(1, 0, 0);
    count_done(3, extra);
    checks += 6;
    if (!r_done) begin failures++; $display("FAIL abort_new_done got=0 exp=1"); end
    if (cap_sad !== 12'd3) begin failures++; $display("FAIL abort_sad got=%0d exp=3", cap_sad); end
    if (cap_mode !== 4'd8) begin failures++; $display("FAIL abort_mode got=%0d exp=8", cap_mode); end
    if (r_xfers != 2) begin failures++; $display("FAIL abort_xfers got=%0d exp=2", r_xfers); end
    if (r_done_cyc - r_last_xfer != 6) begin failures++; $display("FAIL abort_latency got=%0d exp=6", r_done_cyc - r_last_xfer); end
    if (extra != 0) begin failures++; $display("FAIL abort_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_start_priority();
    logic [127:0] o = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] o2 = {$urandom, $urandom, $urandom, $urandom};
    logic [3:0] em; logic [11:0] es; logic [127:0] eb;
    start_block(o);
    block_start = 1'b1; orig_blk = o2; pred_valid = 1'b1; pred_blk = o; pred_mode = 4'd4; pred_last = 1'b1;
    #1; checks++;
    if (pred_ready !== 1'b0) begin failures++; $display("FAIL prio_ready got=%b exp=0", pred_ready); end
    @(negedge clk);
    block_start = 1'b0; pred_valid = 1'b0;
    #1; checks++;
    if (pred_ready !== 1'b1) begin failures++; $display("FAIL prio_still_wait got=%b exp=1", pred_ready); end
    @(negedge clk);
    c_pred.delete(); c_mode.delete();
    c_pred.push_back(o); c_mode.push_back(4'd4);
    ref_best(o2, em, es, eb);
    play(1, 0, 0);
    checks++;
    if (cap_sad !== es) begin failures++; $display("FAIL prio_relatch_sad got=%0d exp=%0d", cap_sad, es); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] o = {$urandom, $urandom, $urandom, $urandom};
    logic [3:0] em; logic [11:0] es; logic [127:0] eb;
    c_pred.delete(); c_mode.delete();
    for (int m = 0; m < 9; m++) begin c_mode.push_back(4'(m)); c_pred.push_back(bump(o, 16, m + 1, 1)); end
    start_block(o);
    play(1, 0, 5);
    reset = 1'b0;
    #1; checks += 4;
    if (pred_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b exp=00", pred_ready, done); end
    if (best_mode !== 4'd0) begin failures++; $display("FAIL midrst_mode got=%0d exp=0", best_mode); end
    if (best_sad !== 12'hfff) begin failures++; $display("FAIL midrst_sad got=%0h exp=fff", best_sad); end
    if (best_blk !== 128'd0) begin failures++; $display("FAIL midrst_blk got=%0h exp=0", best_blk); end
    @(negedge clk);
    reset = 1'b1;
    o = {$urandom, $urandom, $urandom, $urandom};
    c_pred.delete(); c_mode.delete();
    for (int m = 0; m < 9; m++) begin c_mode.push_back(4'(m)); c_pred.push_back(bump(o, $urandom_range(16, 1), $urandom_range(9, 1), 1'($urandom))); end
    ref_best(o, em, es, eb);
    start_block(o);
    play(1, 0, 0);
    checks += 4;
    if (!r_done) begin failures++; $display("FAIL postrst_done got=0 exp=1"); end
    if (cap_mode !== em) begin failures++; $display("FAIL postrst_mode got=%0d exp=%0d", cap_mode, em); end
    if (cap_sad !== es) begin failures++; $display("FAIL postrst_sad got=%0d exp=%0d", cap_sad, es); end
    if (cap_blk !== eb) begin failures++; $display("FAIL postrst_blk got=%0h exp=%0h", cap_blk, eb); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    block_start = 1'b0; pred_valid = 1'b0; pred_last = 1'b0; pred_mode = '0;
    orig_blk = '0; pred_blk = '0;
    test_reset();
    test_best_match();
    test_max_sad();
    test_tie();
    test_stalls();
    test_abort();
    test_start_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
